// File: rtl/uarch_pkg.sv
// uarch_pkg: shared micro-architecture types and constants.
//   writeback_packet_t  - functional-unit writeback / CDB broadcast packet
//   PIPE_WIDTH          - number of CDB broadcast ports
//   CDB_REQ_*           - fixed writeback requester index map for cdb_arbiter
//   NUM_CDB_REQ         - number of CDB requesters
//   CDB_STARVE_LIMIT    - denied cycles before a requester gains absolute priority
package uarch_pkg;

  localparam int PIPE_WIDTH = 2;
  localparam int TAG_W      = 6;
  localparam int ROB_W      = 5;
  localparam int XLEN       = 32;

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    logic [ROB_W-1:0] rob_idx;
    logic [XLEN-1:0]  data;
  } writeback_packet_t;

  localparam int CDB_REQ_ALU0     = 0;
  localparam int CDB_REQ_ALU1     = 1;
  localparam int CDB_REQ_MDU      = 2;
  localparam int CDB_REQ_DMEM     = 3;
  localparam int NUM_CDB_REQ      = 4;
  localparam int CDB_STARVE_LIMIT = 8;

endpackage

// File: rtl/rr_multi_picker.sv
// rr_multi_picker: purely combinational multi-winner round-robin picker.
//   req      - request vector
//   prio     - priority vector (starved requesters), honoured first
//   ptr      - round-robin start index
//   sel      - per-port one-hot selection, port k = k-th winner (all-zero = unused)
//   last_idx - index of the last winner taken from the non-priority pass
//   last_vld - the non-priority pass produced at least one winner
module rr_multi_picker #(
  parameter int NUM_REQ   = 4,
  parameter int NUM_PORTS = 2
) (
  input  logic [NUM_REQ-1:0]                  req,
  input  logic [NUM_REQ-1:0]                  prio,
  input  logic [$clog2(NUM_REQ)-1:0]          ptr,
  output logic [NUM_PORTS-1:0][NUM_REQ-1:0]   sel,
  output logic [$clog2(NUM_REQ)-1:0]          last_idx,
  output logic                                last_vld
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(NUM_PORTS + 1);

  always_comb begin : pick
    logic [IW-1:0] idx;
    logic [CW-1:0] cnt;
    logic          cand;
    sel      = '0;
    last_idx = '0;
    last_vld = 1'b0;
    idx      = '0;
    cnt      = '0;
    cand     = 1'b0;
    // Pass 0 walks starved requesters, pass 1 the rest; both start at ptr,
    // so winners land on ports in the concatenated pass order.
    for (int pass = 0; pass < 2; pass++) begin
      for (int o = 0; o < NUM_REQ; o++) begin
        idx  = IW'((int'(ptr) + o) % NUM_REQ);
        cand = req[idx] & ((pass == 0) ? prio[idx] : ~prio[idx]);
        if (cand && (cnt < CW'(NUM_PORTS))) begin
          for (int k = 0; k < NUM_PORTS; k++) begin
            if (cnt == CW'(k)) sel[k][idx] = 1'b1;
          end
          cnt = cnt + 1'b1;
          if (pass == 1) begin
            last_idx = idx;
            last_vld = 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: arbitrates the four writeback requesters (alu0, alu1, mdu, dmem)
// onto NUM_PORTS common data bus ports. Grants are same-cycle combinational;
// winners are broadcast on registered cdb_ports one cycle later. Round-robin
// with starvation protection (requester denied STARVE_LIMIT cycles goes first).
//   clk, rst          - clock, synchronous active-high reset
//   alu_result[1:0]   - ALU writeback requests (valid = request)
//   mdu_result        - MDU writeback request
//   dmem_result       - load writeback request
//   alu_cdb_gnt[1:0]  - same-cycle grant to each ALU
//   mdu_cdb_gnt       - same-cycle grant to MDU
//   dmem_cdb_gnt      - same-cycle grant to DMEM
//   cdb_ports         - registered CDB broadcast, port k = k-th winner
// Optional build macro CDB_ARB_STATS_EN adds per-requester 32-bit counters
//   stat_grants, stat_stall_cycles (wrap modulo 2^32, cleared by rst).
module cdb_arbiter
  import uarch_pkg::*;
#(
  parameter int NUM_REQ      = NUM_CDB_REQ,
  parameter int NUM_PORTS    = PIPE_WIDTH,
  parameter int STARVE_LIMIT = CDB_STARVE_LIMIT
) (
  input  logic                                clk,
  input  logic                                rst,
  input  writeback_packet_t [1:0]             alu_result,
  input  writeback_packet_t                   mdu_result,
  input  writeback_packet_t                   dmem_result,
  output logic [1:0]                          alu_cdb_gnt,
  output logic                                mdu_cdb_gnt,
  output logic                                dmem_cdb_gnt,
  output writeback_packet_t [NUM_PORTS-1:0]   cdb_ports
`ifdef CDB_ARB_STATS_EN
  ,
  output logic [NUM_REQ-1:0][31:0]            stat_grants,
  output logic [NUM_REQ-1:0][31:0]            stat_stall_cycles
`endif
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int AW = $clog2(STARVE_LIMIT + 1);

  writeback_packet_t [NUM_REQ-1:0]            pkt_p0;
  writeback_packet_t [NUM_PORTS-1:0]          route_p0;
  logic [NUM_REQ-1:0]                         req_p0;
  logic [NUM_REQ-1:0]                         prio_p0;
  logic [NUM_REQ-1:0]                         gnt_p0;
  logic [NUM_PORTS-1:0][NUM_REQ-1:0]          sel_p0;
  logic [IW-1:0]                              last_idx_p0;
  logic                                       last_vld_p0;
  logic [IW-1:0]                              rr_ptr;
  logic [AW-1:0]                              age [NUM_REQ];

  // Stage p0: request collection, selection, same-cycle grants
  assign pkt_p0[CDB_REQ_ALU0] = alu_result[0];
  assign pkt_p0[CDB_REQ_ALU1] = alu_result[1];
  assign pkt_p0[CDB_REQ_MDU]  = mdu_result;
  assign pkt_p0[CDB_REQ_DMEM] = dmem_result;

  always_comb begin
    req_p0  = '0;
    prio_p0 = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_p0[i]  = pkt_p0[i].valid;
      prio_p0[i] = (age[i] == AW'(STARVE_LIMIT));
    end
  end

  rr_multi_picker #(
    .NUM_REQ   (NUM_REQ),
    .NUM_PORTS (NUM_PORTS)
  ) u_picker (
    .req      (req_p0),
    .prio     (prio_p0),
    .ptr      (rr_ptr),
    .sel      (sel_p0),
    .last_idx (last_idx_p0),
    .last_vld (last_vld_p0)
  );

  always_comb begin
    gnt_p0   = '0;
    route_p0 = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      if (!rst) gnt_p0 = gnt_p0 | sel_p0[k];
      for (int i = 0; i < NUM_REQ; i++) begin
        if (sel_p0[k][i]) route_p0[k] = pkt_p0[i];
      end
    end
  end

  assign alu_cdb_gnt  = {gnt_p0[CDB_REQ_ALU1], gnt_p0[CDB_REQ_ALU0]};
  assign mdu_cdb_gnt  = gnt_p0[CDB_REQ_MDU];
  assign dmem_cdb_gnt = gnt_p0[CDB_REQ_DMEM];

  // Stage p1: registered broadcast and arbitration state
  always_ff @(posedge clk) begin
    if (rst) begin
      cdb_ports <= '0;
      rr_ptr    <= '0;
      for (int i = 0; i < NUM_REQ; i++) age[i] <= '0;
    end else begin
      cdb_ports <= route_p0;
      // Only non-priority winners advance the pointer, so servicing a
      // starved requester does not disturb round-robin fairness.
      if (last_vld_p0) rr_ptr <= IW'((int'(last_idx_p0) + 1) % NUM_REQ);
      for (int i = 0; i < NUM_REQ; i++) begin
        if (req_p0[i] && !gnt_p0[i]) begin
          if (age[i] != AW'(STARVE_LIMIT)) age[i] <= age[i] + 1'b1;
        end else begin
          age[i] <= '0;
        end
      end
    end
  end

`ifdef CDB_ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_grants       <= '0;
      stat_stall_cycles <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (gnt_p0[i])                   stat_grants[i]       <= stat_grants[i] + 32'd1;
        if (req_p0[i] && !gnt_p0[i])     stat_stall_cycles[i] <= stat_stall_cycles[i] + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: directed bench for cdb_arbiter with NUM_PORTS = 2.
// Inputs change 1 time unit after a rising edge; grants are sampled 1 unit
// later (combinational), broadcasts 1 unit after the next rising edge.
// Stats checks are compiled when CDB_ARB_STATS_EN is defined.
module tb_cdb_arbiter;
  import uarch_pkg::*;

  logic                          clk = 1'b0;
  logic                          rst;
  writeback_packet_t [1:0]       alu_result;
  writeback_packet_t             mdu_result;
  writeback_packet_t             dmem_result;
  logic [1:0]                    alu_cdb_gnt;
  logic                          mdu_cdb_gnt;
  logic                          dmem_cdb_gnt;
  writeback_packet_t [1:0]       cdb_ports;
`ifdef CDB_ARB_STATS_EN
  logic [3:0][31:0]              stat_grants;
  logic [3:0][31:0]              stat_stall_cycles;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  cdb_arbiter dut (
    .clk          (clk),
    .rst          (rst),
    .alu_result   (alu_result),
    .mdu_result   (mdu_result),
    .dmem_result  (dmem_result),
    .alu_cdb_gnt  (alu_cdb_gnt),
    .mdu_cdb_gnt  (mdu_cdb_gnt),
    .dmem_cdb_gnt (dmem_cdb_gnt),
    .cdb_ports    (cdb_ports)
`ifdef CDB_ARB_STATS_EN
    ,
    .stat_grants       (stat_grants),
    .stat_stall_cycles (stat_stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  function automatic writeback_packet_t mk(input logic [5:0] t);
    writeback_packet_t p;
    p.valid   = 1'b1;
    p.tag     = t;
    p.rob_idx = t[4:0];
    p.data    = 32'hC0DE_0000 | 32'(t);
    return p;
  endfunction

  task automatic idle();
    alu_result  = '0;
    mdu_result  = '0;
    dmem_result = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Grants packed as {alu1, alu0, mdu, dmem}.
  task automatic chk_gnt(input string tag, input logic [1:0] alu, input logic mdu, input logic dmem);
    n_checks++;
    assert ({alu_cdb_gnt, mdu_cdb_gnt, dmem_cdb_gnt} === {alu, mdu, dmem}) else begin
      n_fail++;
      $error("FAIL %s: observed=%b expected=%b", tag,
             {alu_cdb_gnt, mdu_cdb_gnt, dmem_cdb_gnt}, {alu, mdu, dmem});
    end
  endtask

  task automatic chk_ports(input string tag, input writeback_packet_t e0, input writeback_packet_t e1);
    n_checks++;
    assert (cdb_ports[0] === e0) else begin
      n_fail++;
      $error("FAIL %s port0: observed=%h expected=%h", tag, cdb_ports[0], e0);
    end
    n_checks++;
    assert (cdb_ports[1] === e1) else begin
      n_fail++;
      $error("FAIL %s port1: observed=%h expected=%h", tag, cdb_ports[1], e1);
    end
  endtask

  initial begin
    // Reset with requests present: no grants, ports cleared, pointer 0
    rst = 1'b1;
    idle();
    alu_result[0] = mk(6'd1);
    dmem_result   = mk(6'd2);
    #1 chk_gnt("rst_gnt_a", 2'b00, 1'b0, 1'b0);
    tick();
    chk_ports("rst_ports", '0, '0);
    chk_val("rst_rr", 32'(dut.rr_ptr), 32'd0);
    chk_gnt("rst_gnt_b", 2'b00, 1'b0, 1'b0);
    tick();

    // Single request after reset
    rst = 1'b0;
    idle();
    alu_result[0] = mk(6'd5);
    #1 chk_gnt("single_gnt", 2'b01, 1'b0, 1'b0);
    tick();
    chk_ports("single_bcast", mk(6'd5), '0);
    chk_val("single_rr", 32'(dut.rr_ptr), 32'd1);

    // No requests: state holds
    idle();
    #1 chk_gnt("idle_gnt", 2'b00, 1'b0, 1'b0);
    tick();
    chk_ports("idle_bcast", '0, '0);
    chk_val("idle_rr", 32'(dut.rr_ptr), 32'd1);

    // dmem alone: pointer wraps 3 -> 0
    dmem_result = mk(6'd7);
    #1 chk_gnt("wrap_gnt", 2'b00, 1'b0, 1'b1);
    tick();
    chk_ports("wrap_bcast", mk(6'd7), '0);
    chk_val("wrap_rr", 32'(dut.rr_ptr), 32'd0);

    // All four requesting continuously
    alu_result[0] = mk(6'd10);
    alu_result[1] = mk(6'd11);
    mdu_result    = mk(6'd12);
    dmem_result   = mk(6'd13);
    #1 chk_gnt("all4_c1_gnt", 2'b11, 1'b0, 1'b0);
    tick();
    chk_ports("all4_c1_bcast", mk(6'd10), mk(6'd11));
    chk_val("all4_c1_rr", 32'(dut.rr_ptr), 32'd2);
    alu_result[0] = mk(6'd20);
    alu_result[1] = mk(6'd21);
    #1 chk_gnt("all4_c2_gnt", 2'b00, 1'b1, 1'b1);
    tick();
    chk_ports("all4_c2_bcast", mk(6'd12), mk(6'd13));
    chk_val("all4_c2_rr", 32'(dut.rr_ptr), 32'd0);
    mdu_result  = mk(6'd22);
    dmem_result = mk(6'd23);
    #1 chk_gnt("all4_c3_gnt", 2'b11, 1'b0, 1'b0);
    tick();
    chk_ports("all4_c3_bcast", mk(6'd20), mk(6'd21));
    chk_val("all4_c3_rr", 32'(dut.rr_ptr), 32'd2);

    // Hold/handshake: bring pointer back to 0, then mdu loses to two ALUs
    idle();
    dmem_result = mk(6'd30);
    #1 chk_gnt("hold_pre_gnt", 2'b00, 1'b0, 1'b1);
    tick();
    chk_ports("hold_pre_bcast", mk(6'd30), '0);
    chk_val("hold_pre_rr", 32'(dut.rr_ptr), 32'd0);
    idle();
    alu_result[0] = mk(6'd40);
    alu_result[1] = mk(6'd41);
    mdu_result    = mk(6'd42);
    #1 chk_gnt("hold_c1_gnt", 2'b11, 1'b0, 1'b0);
    tick();
    chk_ports("hold_c1_bcast", mk(6'd40), mk(6'd41));
    alu_result[0] = mk(6'd50);
    alu_result[1] = mk(6'd51);
    #1 chk_gnt("hold_c2_gnt", 2'b01, 1'b1, 1'b0);
    tick();
    chk_ports("hold_c2_bcast", mk(6'd42), mk(6'd50));
    chk_val("hold_c2_rr", 32'(dut.rr_ptr), 32'd1);
    idle();
    alu_result[1] = mk(6'd51);
    #1 chk_gnt("hold_c3_gnt", 2'b10, 1'b0, 1'b0);
    tick();
    chk_ports("hold_c3_bcast", mk(6'd51), '0);
    chk_val("hold_c3_rr", 32'(dut.rr_ptr), 32'd2);

    // Starvation: pin the pointer at 0 so the ALUs keep beating dmem
    idle();
    alu_result[0] = mk(6'd31);
    alu_result[1] = mk(6'd32);
    dmem_result   = mk(6'd33);
    force dut.rr_ptr = 2'd0;
    for (int c = 0; c < 8; c++) begin
      #1 chk_gnt($sformatf("starve_c%0d_gnt", c), 2'b11, 1'b0, 1'b0);
      tick();
      chk_val($sformatf("starve_c%0d_age", c), 32'(dut.age[3]), 32'(c + 1));
    end
    #1 chk_gnt("starve_win_gnt", 2'b01, 1'b0, 1'b1);
    tick();
    chk_ports("starve_win_bcast", mk(6'd33), mk(6'd31));
    chk_val("starve_win_age", 32'(dut.age[3]), 32'd0);
    release dut.rr_ptr;

    // Reset in the cycle after a grant
    idle();
    alu_result[0] = mk(6'd44);
    #1 chk_gnt("midrst_pre_gnt", 2'b01, 1'b0, 1'b0);
    tick();
    chk_ports("midrst_pre_bcast", mk(6'd44), '0);
    rst = 1'b1;
    idle();
    alu_result[1] = mk(6'd45);
    #1 chk_gnt("midrst_gnt", 2'b00, 1'b0, 1'b0);
    tick();
    chk_ports("midrst_bcast", '0, '0);
    chk_val("midrst_rr", 32'(dut.rr_ptr), 32'd0);
    rst = 1'b0;
    dmem_result = mk(6'd46);
    #1 chk_gnt("midrst_post_gnt", 2'b10, 1'b0, 1'b1);
    tick();
    chk_ports("midrst_post_bcast", mk(6'd45), mk(6'd46));
    chk_val("midrst_post_rr", 32'(dut.rr_ptr), 32'd0);

`ifdef CDB_ARB_STATS_EN
    // Stats: ten cycles of alu0-only requests after reset
    rst = 1'b1;
    idle();
    tick();
    rst = 1'b0;
    for (int c = 0; c < 10; c++) begin
      alu_result[0] = mk(6'(c));
      tick();
    end
    idle();
    chk_val("stat_grants0", stat_grants[0], 32'd10);
    chk_val("stat_stall0", stat_stall_cycles[0], 32'd0);
    for (int i = 1; i < 4; i++) begin
      chk_val($sformatf("stat_grants%0d", i), stat_grants[i], 32'd0);
      chk_val($sformatf("stat_stall%0d", i), stat_stall_cycles[i], 32'd0);
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
